// File: rtl/gate_op_arbiter_if.sv
// gate_op_arbiter_if: requester and result handshake bundle for gate_op_arbiter
interface gate_op_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(N_REQ)
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ*2-1:0]     req_op;
   logic                   res_valid;
   logic                   res_ready;
   logic [WIDTH-1:0]       res_y;
   logic [IDW-1:0]         res_id;
   logic [15:0]            ops_done;
   modport master (
      output req_valid, req_a, req_b, req_op, res_ready,
      input  req_ready, res_valid, res_y, res_id, ops_done
   );
   modport slave (
      input  req_valid, req_a, req_b, req_op, res_ready,
      output req_ready, res_valid, res_y, res_id, ops_done
   );
endinterface

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin share of one registered AND/OR/XOR/NAND unit
// among N_REQ valid/ready requesters, one operation in flight at a time.
module gate_op_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(N_REQ)
) (
   input logic             clk,
   input logic             rst,
   gate_op_arbiter_if.slave bus
);
   typedef enum logic {IDLE, RESULT} state_t;
   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, grant;
   logic             found, hs;
   logic [WIDTH-1:0] a_sel, b_sel, y_nxt;
   logic [1:0]       op_sel;
   logic             res_valid_r;
   logic [WIDTH-1:0] res_y_r;
   logic [IDW-1:0]   res_id_r;
   logic [15:0]      ops_done_r;
   // Scan from ptr+N-1 down to ptr so the closest valid index after ptr wins.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
            found = 1'b1;
            grant = IDW'((int'(ptr) + k) % N_REQ);
         end
      end
   end
   assign a_sel  = bus.req_a[int'(grant) * WIDTH +: WIDTH];
   assign b_sel  = bus.req_b[int'(grant) * WIDTH +: WIDTH];
   assign op_sel = bus.req_op[int'(grant) * 2 +: 2];
   assign y_nxt  = op_sel == 2'b00 ? (a_sel & b_sel) :
                   op_sel == 2'b01 ? (a_sel | b_sel) :
                   op_sel == 2'b10 ? (a_sel ^ b_sel) : ~(a_sel & b_sel);
   always_comb begin
      state_nxt = state;
      hs        = 1'b0;
      if (state == IDLE) begin
         hs        = found;
         state_nxt = found ? RESULT : IDLE;
      end else begin
         state_nxt = bus.res_ready ? IDLE : RESULT;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= '0;
         res_valid_r <= 1'b0;
         res_y_r     <= '0;
         res_id_r    <= '0;
         ops_done_r  <= '0;
      end else if (hs) begin
         res_y_r     <= y_nxt;
         res_id_r    <= grant;
         res_valid_r <= 1'b1;
         ptr         <= grant == IDW'(N_REQ - 1) ? '0 : grant + IDW'(1);
      end else if (state == RESULT && bus.res_ready) begin
         res_valid_r <= 1'b0;
         ops_done_r  <= ops_done_r + 16'd1;
      end
   end
   assign bus.req_ready = (state == IDLE && found && !rst) ? N_REQ'(1) << grant : '0;
   assign bus.res_valid = res_valid_r;
   assign bus.res_y     = res_y_r;
   assign bus.res_id    = res_id_r;
   assign bus.ops_done  = ops_done_r;
endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter: scoreboard bench with a transaction-level round-robin model
module tb_gate_op_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   localparam int IDW = 2;
   typedef struct {logic [W-1:0] y; logic [IDW-1:0] id;} exp_t;
   logic clk, rst;
   gate_op_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
   gate_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0, errors = 0;
   exp_t q[$];
   logic m_pend = 1'b0;
   int m_ptr = 0;
   logic [15:0] m_cnt = '0;
   int seen_ids[$];
   logic [W-1:0] last_y;
   logic [IDW-1:0] last_id;
   int vcount = 0;
   logic [W-1:0] y0;
   logic [IDW-1:0] id0;
   logic [W-1:0] sweep_exp [4] = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int rr_pick(logic [N-1:0] v, int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction
   function automatic logic [W-1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
      case (op)
         2'd0: return a & b;
         2'd1: return a | b;
         2'd2: return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction
   // Reference model: advances at each edge from the inputs the DUT sees.
   always @(posedge clk) begin
      int g;
      exp_t e;
      if (rst) begin
         m_pend = 1'b0;
         m_ptr = 0;
         m_cnt = '0;
         q.delete();
      end else if (m_pend) begin
         if (bus.res_ready) begin
            m_pend = 1'b0;
            m_cnt = m_cnt + 16'd1;
            void'(q.pop_front());
         end
      end else begin
         g = rr_pick(bus.req_valid, m_ptr);
         if (g >= 0) begin
            e.y = ref_op(bus.req_a[g*W +: W], bus.req_b[g*W +: W], bus.req_op[g*2 +: 2]);
            e.id = IDW'(g);
            q.push_back(e);
            m_pend = 1'b1;
            m_ptr = (g + 1) % N;
         end
      end
   end
   // Monitor: compares DUT outputs against the model in mid-cycle.
   always @(negedge clk) begin
      int g;
      logic [N-1:0] er;
      g = rr_pick(bus.req_valid, m_ptr);
      er = (rst || m_pend || g < 0) ? '0 : N'(1) << g;
      chk("req_ready", bus.req_ready, er);
      chk("res_valid", bus.res_valid, m_pend);
      chk("ops_done", bus.ops_done, m_cnt);
      if (m_pend && bus.res_valid && q.size() > 0) begin
         chk("res_y", bus.res_y, q[0].y);
         chk("res_id", bus.res_id, q[0].id);
      end
      if (bus.res_valid) vcount++;
      if (bus.res_valid && bus.res_ready && !rst) begin
         last_y = bus.res_y;
         last_id = bus.res_id;
         seen_ids.push_back(int'(bus.res_id));
      end
   end
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op, logic v);
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
      bus.req_op[i*2 +: 2] = op;
      bus.req_valid[i] = v;
   endtask
   initial begin
      rst = 1'b1;
      bus.req_valid = '1;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_op = '0;
      bus.res_ready = 1'b0;
      step(3);
      @(negedge clk);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_y", bus.res_y, 0);
      chk("rst_id", bus.res_id, 0);
      chk("rst_cnt", bus.ops_done, 0);
      step(1);
      rst = 1'b0;
      bus.req_valid = '0;
      set_req(0, 8'hF0, 8'h3C, 2'b00, 1'b1);
      bus.res_ready = 1'b1;
      vcount = 0;
      step(1);
      bus.req_valid = '0;
      step(1);
      @(negedge clk);
      chk("single_y", last_y, 8'h30);
      chk("single_id", last_id, 0);
      chk("single_vcycles", vcount, 1);
      chk("single_cnt", bus.ops_done, 1);
      for (int op = 0; op < 4; op++) begin
         step(1);
         set_req(2, 8'hAA, 8'h0F, 2'(op), 1'b1);
         step(1);
         bus.req_valid = '0;
         step(1);
         @(negedge clk);
         chk("sweep_y", last_y, sweep_exp[op]);
         chk("sweep_id", last_id, 2);
      end
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      seen_ids.delete();
      for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom), 2'($urandom), 1'b1);
      bus.res_ready = 1'b1;
      step(16);
      bus.req_valid = '0;
      @(negedge clk);
      chk("rr_cnt", bus.ops_done, 8);
      chk("rr_len", seen_ids.size(), 8);
      for (int i = 0; i < 8; i++) chk("rr_id", i < seen_ids.size() ? seen_ids[i] : -1, i % 4);
      step(1);
      bus.res_ready = 1'b0;
      set_req(1, W'($urandom), W'($urandom), 2'($urandom), 1'b1);
      step(1);
      bus.req_valid = 4'b1001;
      @(negedge clk);
      y0 = bus.res_y;
      id0 = bus.res_id;
      chk("bp_id", bus.res_id, 1);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", bus.res_valid, 1);
         chk("bp_y", bus.res_y, y0);
         chk("bp_idstable", bus.res_id, id0);
         chk("bp_ready", bus.req_ready, 0);
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_drop", bus.res_valid, 0);
      step(1);
      bus.req_valid = '0;
      step(2);
      bus.res_ready = 1'b0;
      set_req(2, W'($urandom), W'($urandom), 2'($urandom), 1'b1);
      step(1);
      bus.req_valid = '0;
      @(negedge clk);
      chk("rm_pend", bus.res_valid, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rm_valid", bus.res_valid, 0);
      chk("rm_y", bus.res_y, 0);
      chk("rm_cnt", bus.ops_done, 0);
      bus.req_valid = 4'b1010;
      bus.res_ready = 1'b1;
      step(1);
      bus.req_valid = '0;
      @(negedge clk);
      chk("rm_grant", bus.res_id, 1);
      step(2);
      bus.res_ready = 1'b0;
      set_req(0, W'($urandom), W'($urandom), 2'($urandom), 1'b1);
      step(1);
      bus.req_valid = 4'b1000;
      step(1);
      bus.req_valid = '0;
      step(1);
      bus.res_ready = 1'b1;
      step(1);
      bus.req_valid = 4'b1010;
      step(1);
      bus.req_valid = '0;
      @(negedge clk);
      chk("wd_grant", bus.res_id, 1);
      step(2);
      @(negedge clk);
      #2;
      force dut.ops_done_r = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1;
      release dut.ops_done_r;
      step(1);
      set_req(0, W'($urandom), W'($urandom), 2'($urandom), 1'b1);
      step(1);
      bus.req_valid = '0;
      step(1);
      @(negedge clk);
      chk("wrap_cnt", bus.ops_done, 0);
      step(1);
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            set_req(i, W'($urandom), W'($urandom), 2'($urandom), $urandom_range(0, 1) == 1);
         bus.res_ready = $urandom_range(0, 9) < 7;
         rst = $urandom_range(0, 99) == 0;
         step(1);
      end
      rst = 1'b0;
      bus.req_valid = '0;
      step(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
